// File: rtl/sorted_topk_reader_if.sv
// Write/read port bundle for sorted_topk_reader: sample push side, ranked pop side
// and buffer status.
interface sorted_topk_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  dropped;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, count, full, dropped
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, count, full, dropped
    );
endinterface

// File: rtl/sorted_topk_reader.sv
// Streaming top-K buffer: keeps the DEPTH largest samples sorted descending and
// pops them largest-first over a valid/ready port.
module sorted_topk_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    sorted_topk_reader_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_t;

    ent_t          ent, shf, nxt;
    logic [CW-1:0] cnt, cnt_s, cnt_n;
    logic [DEPTH-1:0] ge;
    logic          pop, full_s, drop, drop_n;

    assign pop    = (cnt != '0) && bus.out_ready;
    assign cnt_s  = cnt - CW'(pop);
    assign full_s = (cnt_s == CW'(DEPTH));

    // Pop first: the list after removing entry[0] is what the push sees.
    always_comb begin
        shf = ent;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) shf[i] = ent[i+1];
            shf[DEPTH-1] = '0;
        end
    end

    // ge is a prefix mask of held entries that stay ahead of the new sample;
    // using >= places ties after existing equal values.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign ge[g] = (cnt_s > CW'(g)) && (shf[g] >= bus.in_data);
    end

    always_comb begin
        nxt    = shf;
        cnt_n  = cnt_s;
        drop_n = 1'b0;
        if (bus.in_valid) begin
            if (full_s) drop_n = 1'b1;
            if (!full_s || (bus.in_data > shf[DEPTH-1])) begin
                if (!ge[0]) nxt[0] = bus.in_data;
                for (int i = 1; i < DEPTH; i++)
                    if (!ge[i]) nxt[i] = ge[i-1] ? bus.in_data : shf[i-1];
                if (!full_s) cnt_n = cnt_s + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ent  <= '0;
            cnt  <= '0;
            drop <= 1'b0;
        end else if (clear) begin
            ent  <= '0;
            cnt  <= '0;
            drop <= 1'b0;
        end else begin
            ent  <= nxt;
            cnt  <= cnt_n;
            drop <= drop_n;
        end
    end

    assign bus.out_valid = (cnt != '0);
    assign bus.out_data  = ent[0];
    assign bus.count     = cnt;
    assign bus.full      = (cnt == CW'(DEPTH));
    assign bus.dropped   = drop;
endmodule

// File: tb/tb_sorted_topk_reader.sv
// Scoreboard bench for sorted_topk_reader: a sorted-queue model predicts popped
// values and per-cycle status; a negedge monitor compares.
module tb_sorted_topk_reader;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct {
        int          cyc;
        bit          ov;
        logic [DW-1:0] od;
        int          cnt;
        bit          full;
        bit          drop;
    } st_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic clear = 1'b0;

    sorted_topk_reader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sorted_topk_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] model[$];
    logic [DW-1:0] popq[$];
    st_t           stq[$];
    int            ntot = 0;
    int            npass = 0;

    task automatic step(input bit iv, input logic [DW-1:0] d, input bit rdy,
                        input bit clr = 1'b0, input bit rst = 1'b0);
        bit  drop;
        int  idx;
        st_t s;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        clear         = clr;
        resetn        = !rst;
        drop          = 1'b0;
        if (rst || clr) begin
            model.delete();
        end else begin
            if (rdy && model.size() > 0) begin
                popq.push_back(model[0]);
                void'(model.pop_front());
            end
            if (iv) begin
                idx = model.size();
                for (int i = 0; i < model.size(); i++)
                    if (model[i] < d) begin idx = i; break; end
                model.insert(idx, d);
                if (model.size() > DEPTH) begin
                    void'(model.pop_back());
                    drop = 1'b1;
                end
            end
        end
        s.cyc  = cyc + 1;
        s.ov   = model.size() != 0;
        s.od   = (model.size() != 0) ? model[0] : '0;
        s.cnt  = model.size();
        s.full = model.size() == DEPTH;
        s.drop = drop;
        stq.push_back(s);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        st_t s;
        logic [DW-1:0] e;
        if (resetn === 1'b1 && clear === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            ntot++;
            if (popq.size() == 0) begin
                $display("FAIL pop_data cyc=%0d: got pop of %0d, expected no pop", cyc, bus.out_data);
            end else begin
                e = popq.pop_front();
                if (bus.out_data === e) npass++;
                else $display("FAIL pop_data cyc=%0d: got %0d, expected %0d", cyc, bus.out_data, e);
            end
        end
        while (stq.size() > 0 && stq[0].cyc <= cyc) begin
            s = stq.pop_front();
            ntot++;
            if (bus.out_valid === s.ov && bus.out_data === s.od && bus.count === CW'(s.cnt) &&
                bus.full === s.full && bus.dropped === s.drop)
                npass++;
            else
                $display("FAIL status cyc=%0d: got v=%b d=%0d cnt=%0d full=%b drop=%b, expected v=%b d=%0d cnt=%0d full=%b drop=%b",
                         cyc, bus.out_valid, bus.out_data, bus.count, bus.full, bus.dropped,
                         s.ov, s.od, s.cnt, s.full, s.drop);
        end
    end

    task automatic fill_9751();
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 5, 1'b0); step(1'b1, 9, 1'b0);
        step(1'b1, 1, 1'b0); step(1'b1, 7, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        // basic ordering and draining
        fill_9751();
        repeat (4) step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        // eviction and discard when full
        fill_9751();
        step(1'b1, 6, 1'b0);
        step(1'b1, 2, 1'b0);
        step(1'b0, 0, 1'b0);
        // push and pop together when full
        fill_9751();
        step(1'b1, 8, 1'b1);
        repeat (4) step(1'b0, 0, 1'b1);
        // ties, including zero
        step(1'b1, 4, 1'b0); step(1'b1, 4, 1'b0);
        step(1'b1, 0, 1'b0); step(1'b1, 4, 1'b0);
        step(1'b1, 0, 1'b0);
        repeat (4) step(1'b0, 0, 1'b1);
        // push into empty with out_ready high
        step(1'b1, 3, 1'b1);
        step(1'b0, 0, 1'b0);
        // clear and reset mid-stream with push and pop active
        fill_9751();
        step(1'b1, 8, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0);
        fill_9751();
        step(1'b1, 8, 1'b1, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0);
        // extreme values
        step(1'b1, 32'hFFFF_FFFF, 1'b0); step(1'b1, 32'h8000_0000, 1'b0);
        step(1'b1, 32'h7FFF_FFFF, 1'b0); step(1'b1, 0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 1'b0);
        repeat (5) step(1'b0, 0, 1'b1);
        // randomized traffic with small values to force ties
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 9) < 4,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
        repeat (6) step(1'b0, 0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        ntot++;
        if (popq.size() == 0 && stq.size() == 0) npass++;
        else $display("FAIL drain: got %0d pops and %0d status left, expected 0 and 0", popq.size(), stq.size());
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
